ifetch_prefetch_unit: RTL and testbench
=======================================

// Module: ifetch_prefetch_unit
// PURPOSE
// - Instruction fetch front-end, directly upstream of the instruction-memory control FSM.
// - Generates sequential PCs and issues instruction-SRAM reads (mem_en/mem_addr).
// - Tracks fixed-latency read returns and buffers the fetched words in a small prefetch FIFO.
// - Delivers {instr, instr_pc} to decode over a valid/ready handshake.
// - On branch/jump redirect, flushes the FIFO and drops in-flight returns.
// - Pulses pc_changed, which feeds the memory FSM's PC_changed input.
// PARAMETERS
// - RESET_PC    32'h0000_0000  first fetch address after boot
// - MEM_LAT     2              cycles from request (mem_en=1) to mem_rdata valid; range 1..7
// - FIFO_DEPTH  4              prefetch entries; power of 2, 2..16
// PORTS
// - clk            in   1   clock, rising edge
// - rstn           in   1   asynchronous, active-low reset
// - mem_ready      in   1   memory FSM has finished startup (it is in IDLE or later)
// - fsm_stall      in   1   memory FSM stall (I_FSM_STALL_FETCH); blocks new requests
// - redirect_valid in   1   taken branch/jump from execute
// - redirect_pc    in   32  redirect target; bits[1:0] are ignored (treated as 0)
// - mem_en         out  1   read request strobe to instruction SRAM (active high)
// - mem_addr       out  32  byte address of the request
// - mem_rdata      in   32  read data, valid MEM_LAT cycles after the request
// - pc_changed     out  1   one-cycle pulse during the REDIRECT state
// - instr_valid    out  1   FIFO head is valid
// - instr_ready    in   1   decode accepts the head
// - instr          out  32  instruction word at the FIFO head
// - instr_pc       out  32  PC of the FIFO head
// BEHAVIOUR
// - Reset values: mem_en=0, mem_addr=RESET_PC, pc_changed=0, instr_valid=0, instr=0, instr_pc=0.
//   FIFO is empty, in-flight pipe is cleared, epoch=0, state=BOOT.
// - FSM states:
//   - BOOT: mem_en=0. Go to RUN when mem_ready=1.
//     A redirect during BOOT loads fetch_pc but does not pulse pc_changed.
//   - RUN: issue when fsm_stall=0 and fifo_count+inflight_count < FIFO_DEPTH.
//     On issue: mem_en=1, mem_addr=fetch_pc, fetch_pc += 4 (32-bit wrap: 0xFFFF_FFFC -> 0).
//     redirect_valid=1 takes the FSM to REDIRECT.
//   - REDIRECT (exactly 1 cycle): mem_en=0, pc_changed=1, FIFO cleared, epoch toggled,
//     fetch_pc=redirect_pc latched on entry. Then go to RUN.
// - Return tracking:
//   - A MEM_LAT-deep shift pipe carries {valid, epoch, pc} per request.
//   - The pipe-out entry at cycle T+MEM_LAT captures mem_rdata and is pushed only if its
//     epoch equals the current epoch; otherwise it is discarded.
//   - inflight_count = number of valid pipe entries, counting all epochs.
// - Latency: request at cycle T -> instr_valid=1 at T+MEM_LAT+1 if the FIFO was empty.
//   Back-to-back issue gives one instruction per cycle.
// - Handshake: pop when instr_valid & instr_ready.
//   instr and instr_pc stay stable while instr_valid=1 and instr_ready=0.
// - Simultaneous events:
//   - Push and pop in the same cycle: count unchanged.
//   - redirect_valid while in REDIRECT: the new target wins and REDIRECT is extended one cycle.
//   - redirect_valid together with a pop: the redirect wins and the popped word is discarded.
//   - fsm_stall together with redirect_valid: the redirect is still taken.
// - Full/empty: the credit rule means a push never meets a full FIFO.
//   If an overflow is ever detected, the assertion fires (simulation only).
// - Reset mid-operation: all state returns to reset values immediately.
//   Returns still in flight are lost; the next fetch after BOOT is RESET_PC.
// CONFIGURATION
// - IFETCH_PERF_CNT_EN defined: adds output ports perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
//   - perf_fetch_cnt: +1 per issued request.
//   - perf_stall_cnt: +1 per RUN cycle with fsm_stall=1.
//   - Both reset to 0 and wrap at 2^32.
// - IFETCH_PERF_CNT_EN undefined: the ports and the counters are absent; behaviour is otherwise identical.
// TESTING
// - Boot: RESET_PC=0, MEM_LAT=2, mem_ready rises at cycle 5 -> mem_en=1, mem_addr=0 at cycle 6;
//   instr_valid=1, instr_pc=0 at cycle 9.
// - Streaming with instr_ready=1, memory returns data=addr -> instr_pc 0,4,8,12 on consecutive cycles;
//   instr equals instr_pc.
// - Backpressure: instr_ready=0 -> at most FIFO_DEPTH issued; then mem_en=0; head stays instr_pc=0.
//   Releasing instr_ready resumes fetch at addr 0x10.
// - Redirect to 0x100 with 2 requests in flight -> pc_changed one pulse, FIFO empty.
//   Stale returns are dropped; next mem_addr=0x100; first delivered instr_pc=0x100.
// - fsm_stall held for 3 RUN cycles -> no mem_en during those cycles; fetch_pc is held.
//   With IFETCH_PERF_CNT_EN, perf_stall_cnt=3.
// - Wrap: redirect to 0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000.

Source files
------------

// File: rtl/ifetch_prefetch_unit.sv
// rtl/ifetch_prefetch_unit.sv - sequential PC fetch, fixed-latency return tracking and prefetch FIFO
// Optional feature macro: IFETCH_PERF_CNT_EN (fetch/stall performance counters).
module ifetch_prefetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_LAT    = 2,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_ready,
  input  logic        fsm_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        pc_changed,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int SUM_W   = CNT_W + 3;
  // Wider than one bit so back-to-back redirects within MEM_LAT cannot alias an old epoch.
  localparam int EPOCH_W = 3;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         fetch_pc_q, fetch_pc_d;
  logic [EPOCH_W-1:0]  epoch_q, epoch_d;
  logic                issue, flush, push, pop, credit;
  logic [3:0]          inflight_cnt;
  logic [SUM_W-1:0]    used_cnt;

  logic [MEM_LAT-1:0]  pipe_vld_q;
  logic [EPOCH_W-1:0]  pipe_epoch_q [MEM_LAT];
  logic [31:0]         pipe_pc_q    [MEM_LAT];

  logic [31:0]         fifo_instr_q [FIFO_DEPTH];
  logic [31:0]         fifo_pc_q    [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight_cnt = inflight_cnt + {3'b000, pipe_vld_q[i]};
    end
  end

  assign used_cnt = SUM_W'(count_q) + SUM_W'(inflight_cnt);
  assign credit   = used_cnt < SUM_W'(FIFO_DEPTH);

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    pc_changed = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (mem_ready) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid)             state_d = ST_REDIRECT;
        else if (!fsm_stall && credit)  issue   = 1'b1;
      end
      ST_REDIRECT: begin
        pc_changed = 1'b1;
        if (!redirect_valid) state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  assign fetch_pc_d = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC)
                    : (issue ? fetch_pc_q + 32'd4 : fetch_pc_q);
  assign epoch_d    = (state_q == ST_RUN && redirect_valid) ? epoch_q + EPOCH_W'(1) : epoch_q;
  assign flush      = redirect_valid && (state_q != ST_BOOT);

  assign push        = pipe_vld_q[MEM_LAT-1] && (pipe_epoch_q[MEM_LAT-1] == epoch_q) && !flush;
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready && !flush;

  assign mem_en   = issue;
  assign mem_addr = fetch_pc_q;
  assign instr    = fifo_instr_q[rd_ptr_q];
  assign instr_pc = fifo_pc_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      epoch_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      epoch_q    <= epoch_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_vld_q[i]   <= 1'b0;
        pipe_epoch_q[i] <= '0;
        pipe_pc_q[i]    <= '0;
      end
    end else begin
      pipe_vld_q[0]   <= issue;
      pipe_epoch_q[0] <= epoch_q;
      pipe_pc_q[0]    <= fetch_pc_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_vld_q[i]   <= pipe_vld_q[i-1];
        pipe_epoch_q[i] <= pipe_epoch_q[i-1];
        pipe_pc_q[i]    <= pipe_pc_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_instr_q[wr_ptr_q] <= mem_rdata;
        fifo_pc_q[wr_ptr_q]    <= pipe_pc_q[MEM_LAT-1];
        wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_q + {31'd0, issue};
      perf_stall_q <= perf_stall_q + {31'd0, (state_q == ST_RUN) && fsm_stall};
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && !pop && (count_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// tb/tb_ifetch_prefetch_unit.sv - scoreboard bench for ifetch_prefetch_unit
// Fixed-latency memory model returns data equal to the request address.
module tb_ifetch_prefetch_unit;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          MEM_LAT    = 2;
  localparam int          FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn, mem_ready, fsm_stall, redirect_valid, instr_ready;
  logic [31:0] redirect_pc;
  logic        mem_en, pc_changed, instr_valid;
  logic [31:0] mem_addr, mem_rdata, instr, instr_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  int          issued_cnt = 0;
  int          pcc_cnt = 0;
  logic [31:0] exp_fetch_pc;
  logic [31:0] exp_head;
  logic [31:0] exp_q [$];

  logic        lat_vld  [MEM_LAT];
  logic [31:0] lat_addr [MEM_LAT];

  ifetch_prefetch_unit #(
    .RESET_PC(RESET_PC), .MEM_LAT(MEM_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .mem_ready(mem_ready), .fsm_stall(fsm_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pc_changed(pc_changed), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
`ifdef IFETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < MEM_LAT; i++) lat_vld[i] <= 1'b0;
    end else begin
      lat_vld[0]  <= mem_en;
      lat_addr[0] <= mem_addr;
      for (int i = 1; i < MEM_LAT; i++) begin
        lat_vld[i]  <= lat_vld[i-1];
        lat_addr[i] <= lat_addr[i-1];
      end
    end
  end
  assign mem_rdata = (lat_vld[MEM_LAT-1] === 1'b1) ? lat_addr[MEM_LAT-1] : 32'hDEAD_BEEF;

  // Scoreboard: expected PCs enter on issue, leave on decode acceptance; redirect flushes.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      exp_fetch_pc = RESET_PC;
      issued_cnt   = 0;
    end else if (redirect_valid) begin
      exp_q.delete();
      exp_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (instr_valid && instr_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_instr: got pc %h, required no delivery", instr_pc);
        end else begin
          exp_head = exp_q.pop_front();
          if (instr_pc !== exp_head || instr !== exp_head) begin
            errors++;
            $display("FAIL sb_instr: got pc %h instr %h, required %h", instr_pc, instr, exp_head);
          end
        end
      end
      if (mem_en) begin
        checks++;
        if (mem_addr !== exp_fetch_pc) begin
          errors++;
          $display("FAIL sb_fetch_addr: got %h, required %h", mem_addr, exp_fetch_pc);
        end
        exp_q.push_back(exp_fetch_pc);
        exp_fetch_pc = exp_fetch_pc + 32'd4;
        issued_cnt++;
      end
    end
    if (rstn && pc_changed) pcc_cnt++;
  end

  task automatic do_reset(input logic ready);
    @(posedge clk); #1;
    rstn = 1'b0; mem_ready = 1'b0; fsm_stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1; mem_ready = ready;
  endtask

  task automatic test_reset();
    rstn = 1'b0; mem_ready = 1'b0; fsm_stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b, required 0", mem_en); end
    checks++; if (mem_addr !== RESET_PC) begin errors++; $display("FAIL rst_mem_addr: got %h, required %h", mem_addr, RESET_PC); end
    checks++; if (pc_changed !== 1'b0) begin errors++; $display("FAIL rst_pc_changed: got %b, required 0", pc_changed); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid: got %b, required 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h, required 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc: got %h, required 0", instr_pc); end
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  task automatic test_boot();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c == 5) mem_ready = 1'b1;
      @(negedge clk);
      if (c == 5) begin
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL boot_early_en: got %b, required 0", mem_en); end
      end
      if (c == 6) begin
        checks++; if (mem_en !== 1'b1 || mem_addr !== RESET_PC) begin
          errors++; $display("FAIL boot_first_req: got en %b addr %h, required 1 %h", mem_en, mem_addr, RESET_PC); end
      end
      if (c == 8) begin
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL boot_early_valid: got %b, required 0", instr_valid); end
      end
      if (c == 9) begin
        checks++; if (instr_valid !== 1'b1 || instr_pc !== RESET_PC) begin
          errors++; $display("FAIL boot_first_valid: got v %b pc %h, required 1 %h", instr_valid, instr_pc, RESET_PC); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit found = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
        errors++; $display("FAIL bp_head_stable: got v %b pc %h, required 1 0", instr_valid, instr_pc); end
    end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL bp_no_issue: got %b, required 0", mem_en); end
    @(posedge clk); #1;
    checks++; if (issued_cnt != FIFO_DEPTH) begin errors++; $display("FAIL bp_issue_count: got %0d, required %0d", issued_cnt, FIFO_DEPTH); end
    instr_ready = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (mem_en) found = 1;
    end
    checks++; if (!found || mem_addr !== 32'h10) begin
      errors++; $display("FAIL bp_resume: got found %0d addr %h, required 1 00000010", found, mem_addr); end
  endtask

  task automatic test_stream();
    bit found = 0;
    do_reset(1'b1);
    instr_ready = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (instr_valid) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL stream_timeout: got no instr_valid, required one"); end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k) || instr !== 32'(4 * k)) begin
        errors++; $display("FAIL stream_seq: got v %b pc %h instr %h, required 1 %h", instr_valid, instr_pc, instr, 32'(4 * k)); end
    end
  endtask

  task automatic test_redirect();
    int p0;
    bit found = 0;
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    @(posedge clk); #1 redirect_valid = 1'b0;
    p0 = pcc_cnt;
    @(negedge clk);
    checks++; if (pc_changed !== 1'b1 || instr_valid !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL redir_state: got pcc %b v %b en %b, required 1 0 0", pc_changed, instr_valid, mem_en); end
    @(negedge clk);
    checks++; if (pc_changed !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL redir_first_req: got pcc %b en %b addr %h, required 0 1 00000100", pc_changed, mem_en, mem_addr); end
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (instr_valid) found = 1;
    end
    checks++; if (!found || instr_pc !== 32'h100 || instr !== 32'h100) begin
      errors++; $display("FAIL redir_first_instr: got found %0d pc %h, required 1 00000100", found, instr_pc); end
    @(posedge clk); #1;
    checks++; if (pcc_cnt - p0 != 1) begin errors++; $display("FAIL redir_pulse_count: got %0d, required 1", pcc_cnt - p0); end
  endtask

  task automatic test_double_redirect();
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(posedge clk); #1 redirect_pc = 32'h300;
    @(negedge clk);
    checks++; if (pc_changed !== 1'b1) begin errors++; $display("FAIL dbl_pcc1: got %b, required 1", pc_changed); end
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (pc_changed !== 1'b1 || mem_en !== 1'b0) begin
      errors++; $display("FAIL dbl_extended: got pcc %b en %b, required 1 0", pc_changed, mem_en); end
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h300 || pc_changed !== 1'b0) begin
      errors++; $display("FAIL dbl_target: got en %b addr %h pcc %b, required 1 00000300 0", mem_en, mem_addr, pc_changed); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_wrap();
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_top: got en %b addr %h, required 1 fffffffc", mem_en, mem_addr); end
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_zero: got en %b addr %h, required 1 00000000", mem_en, mem_addr); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_stall();
    int n;
    bit found = 0;
    do_reset(1'b1);
    instr_ready = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (mem_en) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL stall_no_start: got no mem_en, required one"); end
    repeat (3) @(posedge clk);
    #1 fsm_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL stall_blocks: got %b, required 0", mem_en); end
      if (i < 2) @(posedge clk);
    end
    @(posedge clk); #1 fsm_stall = 1'b0;
    n = issued_cnt;
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'(n * 4)) begin
      errors++; $display("FAIL stall_resume: got en %b addr %h, required 1 %h", mem_en, mem_addr, 32'(n * 4)); end
`ifdef IFETCH_PERF_CNT_EN
    checks++; if (perf_stall_cnt !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d, required 3", perf_stall_cnt); end
    checks++; if (perf_fetch_cnt !== 32'(n)) begin errors++; $display("FAIL perf_fetch: got %0d, required %0d", perf_fetch_cnt, n); end
`endif
    repeat (6) @(negedge clk);
  endtask

  task automatic test_boot_redirect();
    bit found = 0;
    do_reset(1'b0);
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(posedge clk); #1 redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (pc_changed !== 1'b0 || mem_en !== 1'b0) begin
        errors++; $display("FAIL bootredir_quiet: got pcc %b en %b, required 0 0", pc_changed, mem_en); end
    end
    @(posedge clk); #1 mem_ready = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (mem_en) found = 1;
    end
    checks++; if (!found || mem_addr !== 32'h40) begin
      errors++; $display("FAIL bootredir_target: got found %0d addr %h, required 1 00000040", found, mem_addr); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    do_reset(1'b1);
    instr_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0 || pc_changed !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl: got en %b pcc %b v %b, required 0 0 0", mem_en, pc_changed, instr_valid); end
    checks++; if (mem_addr !== RESET_PC || instr !== 32'h0 || instr_pc !== 32'h0) begin
      errors++; $display("FAIL midrst_data: got addr %h instr %h pc %h, required %h 0 0", mem_addr, instr, instr_pc, RESET_PC); end
    @(posedge clk); @(posedge clk); #1 rstn = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (mem_en) found = 1;
    end
    checks++; if (!found || mem_addr !== RESET_PC) begin
      errors++; $display("FAIL midrst_refetch: got found %0d addr %h, required 1 %h", found, mem_addr, RESET_PC); end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_boot();
    test_backpressure();
    repeat (10) @(negedge clk);
    test_stream();
    test_redirect();
    test_double_redirect();
    test_wrap();
    test_stall();
    test_boot_redirect();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
